// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key expansion slice.
//   NR      : index of the final AES-128 round key
//   RCON    : round constants used by key expansion, indexed by round 0..NR-1
//   key_sched_state_t : key schedule controller state
//   gf_mul  : GF(2^8) multiply modulo x^8+x^4+x^3+x+1, used by the S-box
package aes_pkg;

  localparam int NR = 10;

  localparam logic [7:0] RCON [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } key_sched_state_t;

  // Shift-and-add multiply; each step doubles the multiplicand (xtime).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] m;
    p = 8'h00;
    m = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
//   x : input byte
//   s : substituted byte
// The multiplicative inverse is x^254 in GF(2^8) (0 maps to 0 naturally),
// formed as the product of the seven squares x^2..x^128, followed by the
// standard affine transform with constant 0x63.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] s
);

  logic [7:0] p2, p4, p8, p16, p32, p64, p128;
  logic [7:0] inv;

  assign p2   = gf_mul(x,   x);
  assign p4   = gf_mul(p2,  p2);
  assign p8   = gf_mul(p4,  p4);
  assign p16  = gf_mul(p8,  p8);
  assign p32  = gf_mul(p16, p16);
  assign p64  = gf_mul(p32, p32);
  assign p128 = gf_mul(p64, p64);

  // 2+4+8+16+32+64+128 = 254
  assign inv = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                      gf_mul(gf_mul(p32, p64), p128));

  // Affine map: inv xor its left rotations by 1..4, xor 0x63.
  assign s = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
//   word : input word
//   sub  : word with every byte substituted
// Four S-box instances, purely combinational, no state.
module aes_sub_word (
  input  logic [31:0] word,
  output logic [31:0] sub
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .x (word[8*g +: 8]),
      .s (sub[8*g +: 8])
    );
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion engine.
// Accepts one cipher key, then presents round keys 0..NR one per handshake.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   key_valid : key_in is valid
//   key_ready : idle, can accept a key
//   key_in    : cipher key, word0 = [127:96]
//   rk_valid  : rk_out holds a valid round key
//   rk_ready  : downstream accepts rk_out
//   rk_out    : current round key, same word order as key_in
//   rk_index  : round number of rk_out
//   busy      : high while expanding
// The next round key is computed combinationally from rk_out in one cycle;
// a single SubWord block is shared by every round.
module aes_key_schedule
  import aes_pkg::*;
#(
  // Only 10 (AES-128) is meaningful; the round constant table is sized for it.
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_index,
  output logic         busy
);

  key_sched_state_t state;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sw, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;
  logic [7:0]   rcon;
  logic         last;

  assign {w0, w1, w2, w3} = rk_out;

  // RotWord: rotate left by one byte.
  assign rot = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .word (rot),
    .sub  (sw)
  );

  // Round constant for the current index; zero outside the table range,
  // which only happens at the last key where next_key is never used.
  always_comb begin
    rcon = 8'h00;
    for (int i = 0; i < $size(RCON); i++) begin
      if (rk_index == 4'(i)) rcon = RCON[i];
    end
  end

  assign t  = sw ^ {rcon, 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  assign last = (rk_index == 4'(NR));
  assign busy = (state == EXPAND);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_out    <= '0;
      rk_index  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid && key_ready) begin
            rk_out    <= key_in;
            rk_index  <= '0;
            rk_valid  <= 1'b1;
            key_ready <= 1'b0;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          if (rk_valid && rk_ready) begin
            if (!last) begin
              rk_out   <= next_key;
              rk_index <= rk_index + 4'd1;
            end else begin
              // Final key consumed: rk_out/rk_index keep their last values.
              rk_valid  <= 1'b0;
              key_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          key_ready <= 1'b1;
          rk_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: a textbook word-array key
// expansion model, a negedge monitor that scores every transfer and every
// stalled cycle, and directed plus randomized scenarios.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key_in = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         busy;

  aes_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (rk_out),
    .rk_index  (rk_index),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int r = 0;
    int aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa << 1;
      if (aa > 255) aa = aa ^ 'h11b;
    end
    return 8'(r);
  endfunction

  // S-box from its definition: brute-force inverse, then bitwise affine map.
  function automatic logic [7:0] m_sbox(input logic [7:0] v);
    logic [7:0] b = 8'h00;
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    for (int y = 1; y < 256; y++)
      if (v != 0 && m_mul(v, 8'(y)) == 8'h01) b = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    return s;
  endfunction

  logic [127:0] exp_sched [11];

  task automatic load_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {m_sbox(tmp[31:24]), m_sbox(tmp[23:16]), m_sbox(tmp[15:8]), m_sbox(tmp[7:0])};
        tmp = tmp ^ {rc, 24'h0};
        rc  = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- monitor ----------------
  int           xfer_cnt = 0;
  int           sched_base = 0;
  logic [127:0] got_rk [11];
  logic         prev_stall = 1'b0;
  logic [127:0] prev_out;
  logic [3:0]   prev_idx;

  always @(negedge clk) begin
    int k;
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_out", rk_out, prev_out);
        check("stall_idx", 128'(rk_index), 128'(prev_idx));
        check("stall_vld", 128'(rk_valid), 128'(1));
      end
      check("busy_vs_vld", 128'(busy), 128'(rk_valid));
      check("kr_vs_vld", 128'(key_ready), 128'(!rk_valid));
      if (rk_valid && rk_ready) begin
        k = xfer_cnt - sched_base;
        if (k > 10) check("extra_rk", 128'(k), 128'(10));
        else begin
          check("rk_idx", 128'(rk_index), 128'(k));
          check("rk_key", rk_out, exp_sched[k]);
          got_rk[k] = rk_out;
        end
        xfer_cnt++;
      end
      prev_stall = rk_valid && !rk_ready;
      prev_out   = rk_out;
      prev_idx   = rk_index;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- scenarios ----------------
  // mode 0: always ready; 1: random ready + 5-cycle stall at idx3;
  // 2: foreign key pulse at idx4; 3: reset at idx6 (aborts)
  task automatic run_key(input logic [127:0] key, input int mode, output int cycles);
    int guard = 0;
    bit stall_done = 0;
    bit pulse_done = 0;
    load_model(key);
    sched_base = xfer_cnt;
    while (!key_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!key_ready) check("key_ready_wait", 128'(key_ready), 128'(1));
    key_in    = key;
    key_valid = 1'b1;
    rk_ready  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    cycles = 0;
    check("acc_vld", 128'(rk_valid), 128'(1));
    check("acc_idx", 128'(rk_index), 128'(0));
    check("acc_key", rk_out, key);
    while (xfer_cnt - sched_base < 11 && cycles < 300) begin
      rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1 && rk_index == 4'd3 && !stall_done) begin
        stall_done = 1;
        rk_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; cycles++; end
        rk_ready = 1'b1;
      end
      if (mode == 2 && rk_index == 4'd4 && !pulse_done) begin
        pulse_done = 1;
        key_in = ~key;
        key_valid = 1'b1;
        check("pulse_kr", 128'(key_ready), 128'(0));
      end else begin
        key_valid = 1'b0;
      end
      if (mode == 3 && rk_index == 4'd6) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_vld", 128'(rk_valid), 128'(0));
        check("rst_idx", 128'(rk_index), 128'(0));
        check("rst_out", rk_out, 128'(0));
        check("rst_kr", 128'(key_ready), 128'(1));
        check("rst_busy", 128'(busy), 128'(0));
        cycles = -1;
        return;
      end
      @(posedge clk); #1;
      cycles++;
    end
    key_valid = 1'b0;
    if (cycles >= 300) check("sched_timeout", 128'(xfer_cnt - sched_base), 128'(11));
    check("done_kr", 128'(key_ready), 128'(1));
    check("done_vld", 128'(rk_valid), 128'(0));
    check("done_idx", 128'(rk_index), 128'(10));
    check("done_out", rk_out, exp_sched[10]);
  endtask

  task automatic run_b2b(input logic [127:0] k1, input logic [127:0] k2);
    int c = 0;
    load_model(k1);
    sched_base = xfer_cnt;
    key_in = k1; key_valid = 1'b1; rk_ready = 1'b1;
    @(posedge clk); #1;
    key_in = k2;  // key_valid stays high throughout the first schedule
    while (xfer_cnt - sched_base < 11 && c < 100) begin @(posedge clk); #1; c++; end
    check("b2b_first_len", 128'(c), 128'(11));
    check("b2b_gap_kr", 128'(key_ready), 128'(1));
    check("b2b_gap_vld", 128'(rk_valid), 128'(0));
    load_model(k2);
    sched_base = xfer_cnt;
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("b2b_acc_vld", 128'(rk_valid), 128'(1));
    check("b2b_acc_out", rk_out, k2);
    c = 0;
    while (xfer_cnt - sched_base < 11 && c < 100) begin @(posedge clk); #1; c++; end
    check("b2b_second_len", 128'(c), 128'(11));
    check("b2b_last", got_rk[10], exp_sched[10]);
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    int cyc;
    logic [127:0] rk;
    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_kr", 128'(key_ready), 128'(1));
    check("reset_vld", 128'(rk_valid), 128'(0));
    check("reset_out", rk_out, 128'(0));
    check("reset_idx", 128'(rk_index), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    rst_n = 1'b1;

    // rk_ready in IDLE has no effect
    rk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_rdy_vld", 128'(rk_valid), 128'(0));
    check("idle_rdy_idx", 128'(rk_index), 128'(0));

    // FIPS-197 vector, full throughput
    run_key(FIPS_KEY, 0, cyc);
    check("fips_len", 128'(cyc), 128'(11));
    check("fips_idx0", got_rk[0], FIPS_KEY);
    check("fips_idx1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_idx10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // same key, backpressure
    run_key(FIPS_KEY, 1, cyc);
    check("stall_idx10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // foreign key pulse mid-schedule
    run_key(FIPS_KEY, 2, cyc);
    check("pulse_idx10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // reset mid-expansion, then a fresh key
    run_key(FIPS_KEY, 3, cyc);
    rk = {$urandom, $urandom, $urandom, $urandom};
    run_key(rk, 0, cyc);
    check("post_rst_len", 128'(cyc), 128'(11));

    // all-zero key
    run_key(128'h0, 0, cyc);
    check("zero_idx1", got_rk[1], 128'h62636363626363636263636362636363);
    check("zero_idx10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // back-to-back keys
    run_b2b({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});

    // randomized keys with random backpressure
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      run_key(rk, (n % 2 == 0) ? 1 : 0, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Sequential AES-128 key expansion engine.
- Accepts one 128-bit cipher key and emits round keys 0..10 in order, one per output handshake.
- Feeds the AddRoundKey stage that sits ahead of SubBytes in the round datapath.
- Reuses the existing SBox module for SubWord: 4 instances, shared across all rounds.

Parameters:
NR, 10, index of the final round key. Only 10 (AES-128) is legal; the rcon table is sized for it.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, synchronous, active-low
key_valid  input  1  key_in is valid
key_ready  output  1  block is idle and can accept a key
key_in  input  128  cipher key; word0 = [127:96], word3 = [31:0]
rk_valid  output  1  rk_out holds a valid round key
rk_ready  input  1  downstream accepts rk_out
rk_out  output  128  current round key, same word order as key_in
rk_index  output  4  round number of rk_out, 0..10
busy  output  1  expansion in progress; equals the state EXPAND

Behaviour:
- Reset: clk, rst_n, is synchronous and active-low, and is applied on the rising edge of clk while rst_n=0. Outputs after reset:
  - key_ready=1
  - rk_valid=0
  - rk_out=0
  - rk_index=0
  - busy=0
  - state=IDLE
- State machine: two states, IDLE and EXPAND.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid&&key_ready: rk_out<=key_in, rk_index<=0, then go to EXPAND.
  - rk_valid=1 on the cycle after acceptance, giving latency 1.
- EXPAND:
  - key_ready=0, rk_valid=1.
  - On rk_valid&&rk_ready with rk_index<NR: rk_out<=next_key(rk_out, rcon[rk_index]) and rk_index<=rk_index+1. The next key is valid the following cycle.
  - On rk_valid&&rk_ready with rk_index==NR: go to IDLE, rk_valid<=0, key_ready<=1 the next cycle. rk_out and rk_index hold their last values.
  - No handshake: rk_out, rk_index and rk_valid hold stable. Backpressure of any length is allowed.
- next_key computation:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - RotWord(w3) = {w3[23:0], w3[31:24]}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - The combinational path is one cycle, with no internal pipeline.
- rcon[0..9] = 01,02,04,08,10,20,40,80,1B,36. Index range is 0..NR-1.
- Throughput: one round key per cycle when rk_ready is held high. A full schedule is 11 transfers plus 1 cycle of acceptance latency.
- Boundary conditions:
  - key_valid during EXPAND: ignored, no state change (key_ready=0).
  - key_valid asserted on the same cycle the final key is accepted: ignored; key_ready rises the next cycle.
  - rst_n=0 mid-expansion: abort and return to reset values on that edge; no partial output.
  - rk_ready high in IDLE: no effect.
  - rk_index never exceeds NR and never wraps.

Decomposition:
- aes_pkg holds:
  - the NR constant
  - the RCON array of 10 bytes
  - the state enum typedef key_sched_state_t {IDLE, EXPAND}
- Sub-module aes_sub_word: 32-bit in and out, built from 4 SBox instances, purely combinational. Instantiated once in aes_key_schedule.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx0 equals the key; idx1=a0fafe1788542cb123a339392a6c7605; idx10=d014f9a8c9ee2589e13f0cc8b6630ca6. This takes 11 consecutive cycles starting 1 cycle after acceptance, after which key_ready=1.
- Same key with rk_ready toggled randomly and held low for 5 cycles at idx3 -> rk_out and rk_index are stable while stalled; the sequence matches the no-stall run bit-exactly.
- key_valid pulsed with a different key at idx4 -> key_ready=0, the pulse is ignored, and the remaining keys match the original schedule.
- rst_n=0 for 1 cycle at idx6 -> the next cycle shows rk_valid=0, rk_index=0, rk_out=0, key_ready=1. A new key is then accepted and expanded correctly.
- Key all-zero -> idx1=62636363626363636263636362636363; idx10=b4ef5bcb3e92e21123e951cf6f8f188e.
- Back-to-back keys: second key_valid held high continuously -> accepted on the cycle after idx10 is transferred; the second schedule starts correctly.
